// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared widths and types for the GPR writeback arbiter slice.
package gpr_wb_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // One writeback transfer: destination index plus data.
    typedef struct packed {
        reg_idx_t          rdn;
        logic [XLEN-1:0]   rdd;
    } wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or after
// the rotating pointer; the pointer moves past the winner on each accept.
module gpr_wb_arbiter_rr_arbiter #(
    parameter  int unsigned N  = 3,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn_h,
    input  logic [N-1:0]  valid_i,
    input  logic          accept_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] win_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // Grant search starting at the pointer, wrapping mod N; pointer advance on accept.
    always_comb begin
        grant_o = '0;
        win_o   = '0;
        idx     = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr_q) + k) % N);
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                win_o        = idx;
                found        = 1'b1;
            end
        end
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (32'(win_o) == N - 1) ? '0 : win_o + PW'(1);
        end
    end

    // Rotating pointer register.
    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port among NREQ writeback sources and keeps a
// busy scoreboard so the issue stage can stall on pending destinations.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 3,
    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rstn_h,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*REG_AW-1:0]   req_rdn,
    input  logic [NREQ*XLEN-1:0]     req_rdd,
    output logic [NREQ-1:0]          req_ready,
    output logic                     wbe,
    output logic [REG_AW-1:0]        rdn,
    output logic [XLEN-1:0]          rdd,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_rdn,
    output logic                     issue_ready,
    input  logic [REG_AW-1:0]        rs1n,
    input  logic [REG_AW-1:0]        rs2n,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [NREGS-1:0]         busy_vec
);

    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    win;
    logic             accept;
    logic             issue_take;
    wb_req_t          sel;
    wb_req_t          wb_q;
    wb_req_t          wb_d;
    logic             wbe_q;
    logic             wbe_d;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    gpr_wb_arbiter_rr_arbiter #(.N(NREQ)) u_arb (
        .clk      (clk),
        .rstn_h   (rstn_h),
        .valid_i  (req_valid),
        .accept_i (accept),
        .grant_o  (grant),
        .win_o    (win)
    );

    assign accept     = |(req_valid & grant);
    assign issue_take = issue_valid & issue_ready;

    // Winner's payload; only meaningful when accept is high.
    always_comb begin
        sel.rdn = req_rdn[int'(win) * int'(REG_AW) +: REG_AW];
        sel.rdd = req_rdd[int'(win) * int'(XLEN) +: XLEN];
    end

    // Next state of the write port and scoreboard; a set overrides a same-edge clear.
    always_comb begin
        wb_d   = wb_q;
        wbe_d  = 1'b0;
        busy_d = busy_q;
        if (accept) begin
            wb_d           = sel;
            wbe_d          = (sel.rdn != '0);
            busy_d[sel.rdn] = 1'b0;
        end
        if (issue_take) begin
            busy_d[issue_rdn] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Write port and scoreboard registers; reset drops reservations and in-flight writes.
    always_ff @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            wb_q   <= '0;
            wbe_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            wb_q   <= wb_d;
            wbe_q  <= wbe_d;
            busy_q <= busy_d;
        end
    end

    assign req_ready   = grant;
    assign wbe         = wbe_q;
    assign rdn         = wb_q.rdn;
    assign rdd         = wb_q.rdd;
    assign busy_vec    = busy_q;
    assign issue_ready = ~busy_q[issue_rdn];
    assign rs1_busy    = busy_q[rs1n];
    assign rs2_busy    = busy_q[rs2n];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter with a per-cycle reference model.
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    localparam int NREQ = 3;

    logic                   clk;
    logic                   rstn_h;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*REG_AW-1:0] req_rdn;
    logic [NREQ*XLEN-1:0]   req_rdd;
    logic [NREQ-1:0]        req_ready;
    logic                   wbe;
    logic [REG_AW-1:0]      rdn;
    logic [XLEN-1:0]        rdd;
    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_rdn;
    logic                   issue_ready;
    logic [REG_AW-1:0]      rs1n;
    logic [REG_AW-1:0]      rs2n;
    logic                   rs1_busy;
    logic                   rs2_busy;
    logic [NREGS-1:0]       busy_vec;

    int tests;
    int fails;
    bit mdl_on;

    gpr_wb_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rstn_h      (rstn_h),
        .req_valid   (req_valid),
        .req_rdn     (req_rdn),
        .req_rdd     (req_rdd),
        .req_ready   (req_ready),
        .wbe         (wbe),
        .rdn         (rdn),
        .rdd         (rdd),
        .issue_valid (issue_valid),
        .issue_rdn   (issue_rdn),
        .issue_ready (issue_ready),
        .rs1n        (rs1n),
        .rs2n        (rs2n),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .busy_vec    (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: set of pending registers, last winner, last write.
    bit              m_pend [NREGS];
    int              m_last;
    logic            m_wbe;
    logic [4:0]      m_rdn;
    logic [31:0]     m_rdd;

    int              e_win;
    logic [NREQ-1:0] e_grant;
    logic [4:0]      e_rdn_w;
    logic [31:0]     e_rdd_w;
    logic            e_iready;
    logic [31:0]     e_busy;

    always_comb begin
        e_win = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (e_win < 0 && req_valid[(m_last + 1 + k) % NREQ] == 1'b1)
                e_win = (m_last + 1 + k) % NREQ;
        end
        e_grant = '0;
        e_rdn_w = '0;
        e_rdd_w = '0;
        if (e_win >= 0) begin
            e_grant[e_win] = 1'b1;
            e_rdn_w = req_rdn[e_win * 5 +: 5];
            e_rdd_w = req_rdd[e_win * 32 +: 32];
        end
        e_iready = !m_pend[issue_rdn];
        for (int i = 0; i < 32; i++) e_busy[i] = m_pend[i];
    end

    always @(posedge clk or negedge rstn_h) begin
        if (!rstn_h) begin
            for (int i = 0; i < 32; i++) m_pend[i] <= 1'b0;
            m_last <= NREQ - 1;
            m_wbe  <= 1'b0;
            m_rdn  <= '0;
            m_rdd  <= '0;
        end else begin
            if (e_win >= 0) begin
                m_pend[e_rdn_w] <= 1'b0;
                m_last <= e_win;
                m_rdn  <= e_rdn_w;
                m_rdd  <= e_rdd_w;
                m_wbe  <= (e_rdn_w != 5'd0);
            end else begin
                m_wbe <= 1'b0;
            end
            if (issue_valid && e_iready && issue_rdn != 5'd0)
                m_pend[issue_rdn] <= 1'b1;
        end
    end

    // Compare every cycle away from the rising edge.
    always @(negedge clk) begin
        if (mdl_on && rstn_h) begin
            chk("req_ready",   64'(req_ready),   64'(e_grant));
            chk("issue_ready", 64'(issue_ready), 64'(e_iready));
            chk("rs1_busy",    64'(rs1_busy),    64'(m_pend[rs1n]));
            chk("rs2_busy",    64'(rs2_busy),    64'(m_pend[rs2n]));
            chk("busy_vec",    64'(busy_vec),    64'(e_busy));
            chk("wbe",         64'(wbe),         64'(m_wbe));
            chk("rdn",         64'(rdn),         64'(m_rdn));
            chk("rdd",         64'(rdd),         64'(m_rdd));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rn, input logic [31:0] d);
        req_rdn[i * 5 +: 5]   = rn;
        req_rdd[i * 32 +: 32] = d;
    endtask

    logic [NREQ-1:0] rr_seq [6];

    initial begin
        tests = 0;
        fails = 0;
        mdl_on = 1'b0;
        rstn_h = 1'b0;
        req_valid = '0;
        req_rdn = '0;
        req_rdd = '0;
        issue_valid = 1'b0;
        issue_rdn = '0;
        rs1n = '0;
        rs2n = 5'd4;
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100;
        rr_seq[3] = 3'b001; rr_seq[4] = 3'b010; rr_seq[5] = 3'b100;

        repeat (2) @(posedge clk);
        #1 rstn_h = 1'b1;
        mdl_on = 1'b1;
        #1;
        chk("rst_wbe",   64'(wbe),       64'd0);
        chk("rst_rdn",   64'(rdn),       64'd0);
        chk("rst_rdd",   64'(rdd),       64'd0);
        chk("rst_busy",  64'(busy_vec),  64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);

        // Async reset with reservations 4..7 pending and a write in flight.
        issue_valid = 1'b1; issue_rdn = 5'd4; step();
        issue_rdn = 5'd5; step();
        issue_rdn = 5'd6; step();
        issue_rdn = 5'd7;
        set_req(0, 5'd9, 32'h0000_1234); req_valid = 3'b001;
        step();
        issue_valid = 1'b0; req_valid = '0;
        #1;
        chk("t1_busy_pre", 64'(busy_vec), 64'h0000_00F0);
        chk("t1_wbe_pre",  64'(wbe),      64'd1);
        rstn_h = 1'b0;
        #1;
        chk("t1_busy_rst", 64'(busy_vec), 64'd0);
        chk("t1_wbe_rst",  64'(wbe),      64'd0);
        chk("t1_rdn_rst",  64'(rdn),      64'd0);
        chk("t1_rdd_rst",  64'(rdd),      64'd0);
        step();
        rstn_h = 1'b1;
        #1;

        // Reserve x5, then ALU writes it back.
        issue_valid = 1'b1; issue_rdn = 5'd5; rs1n = 5'd5;
        step();
        issue_valid = 1'b0;
        set_req(0, 5'd5, 32'hDEAD_BEEF); req_valid = 3'b001;
        #1;
        chk("t2_rs1_busy_pre", 64'(rs1_busy), 64'd1);
        step();
        chk("t2_wbe",      64'(wbe),         64'd1);
        chk("t2_rdn",      64'(rdn),         64'd5);
        chk("t2_rdd",      64'(rdd),         64'hDEAD_BEEF);
        chk("t2_busy5",    64'(busy_vec[5]), 64'd0);
        chk("t2_rs1_busy", 64'(rs1_busy),    64'd0);
        req_valid = '0;

        // Write to x0 from requester 1 leaves the scoreboard alone.
        issue_valid = 1'b1; issue_rdn = 5'd3;
        step();
        issue_valid = 1'b0;
        set_req(1, 5'd0, 32'h0000_0055); req_valid = 3'b010;
        #1;
        chk("t4_ready", 64'(req_ready), 64'b010);
        step();
        chk("t4_wbe",  64'(wbe),      64'd0);
        chk("t4_busy", 64'(busy_vec), 64'h0000_0008);
        set_req(2, 5'd3, 32'h0000_0033); req_valid = 3'b100;
        #1;
        chk("t4b_ready", 64'(req_ready), 64'b100);
        step();
        chk("t4b_busy", 64'(busy_vec), 64'd0);
        chk("t4b_rdn",  64'(rdn),      64'd3);
        req_valid = '0;

        // All three valid from pointer 0: strict rotation, one write per cycle.
        set_req(0, 5'd10, 32'hA0A0_0000);
        set_req(1, 5'd11, 32'hA1A1_0001);
        set_req(2, 5'd12, 32'hA2A2_0002);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("t3_grant", 64'(req_ready), 64'(rr_seq[c]));
            step();
            chk("t3_wbe", 64'(wbe), 64'd1);
            chk("t3_rdn", 64'(rdn), 64'(10 + (c % 3)));
        end
        req_valid = '0;

        // Lone requester 2 from pointer 0; pointer wraps back to 0.
        set_req(2, 5'd13, 32'h0000_0066); req_valid = 3'b100;
        #1;
        chk("t6_ready", 64'(req_ready), 64'b100);
        step();
        req_valid = 3'b111;
        #1;
        chk("t6_ptr_ready", 64'(req_ready), 64'b001);
        req_valid = '0;
        step();

        // Same-edge clear and set of x7: the reservation survives.
        set_req(0, 5'd7, 32'h0000_0077); req_valid = 3'b001;
        issue_valid = 1'b1; issue_rdn = 5'd7;
        #1;
        chk("t5_iready", 64'(issue_ready), 64'd1);
        step();
        req_valid = '0;
        #1;
        chk("t5_busy7",        64'(busy_vec[7]), 64'd1);
        chk("t5_iready_again", 64'(issue_ready), 64'd0);
        issue_rdn = 5'd0;
        #1;
        chk("t5_x0_ready", 64'(issue_ready), 64'd1);
        step();
        chk("t5_x0_busy", 64'(busy_vec), 64'h0000_0080);
        issue_valid = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
